// File: rtl/stack_queue_pkg.sv
// Shared constants and pointer helpers for the stack_queue buffer.
// Pointer helpers use int unsigned arithmetic. Callers cast the result back to
// their own pointer width.
package stack_queue_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    // Increment with explicit wrap DEPTH-1 -> 0
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    // Decrement with explicit wrap 0 -> DEPTH-1
    function automatic int unsigned ptr_dec(input int unsigned ptr, input int unsigned depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

    // (ptr + off) mod depth, assuming ptr < depth
    function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned off,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + (off % depth);
        return (sum >= depth) ? sum - depth : sum;
    endfunction

endpackage

// File: rtl/sq_regfile.sv
// DEPTH x WIDTH storage for stack_queue: one synchronous write port and two
// asynchronous read ports. The array has no reset; the consumers mask reads
// of unwritten slots.
//   clk        : write clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_a_i  : read port A address (dout)
//   rdata_a_o  : read port A data
//   raddr_b_i  : read port B address (peek)
//   rdata_b_o  : read port B data
module sq_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [IW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/stack_queue.sv
// Parametrised LIFO/FIFO buffer on a circular register array. Mode can only
// change while the buffer is empty. Provides occupancy count, peek at any
// depth, synchronous clear and sticky overflow/underflow flags.
//   clk, rst             : clock, async active-high reset
//   clear                : synchronous flush
//   mode_sel / mode      : requested / active mode (0 LIFO, 1 FIFO)
//   push, pop, din       : operation requests and push data
//   dout                 : top (LIFO) or head (FIFO), 0 when empty
//   peek_idx/peek_data/peek_valid : inspect entry at depth peek_idx
//   count, empty, full   : occupancy status
//   overflow, underflow  : sticky error flags
module stack_queue
    import stack_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             mode_sel,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [IW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             mode,
    output logic             overflow,
    output logic             underflow
);

    logic [IW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mode_q, mode_d, overflow_q, overflow_d, underflow_q, underflow_d;

    logic             we;
    logic [IW-1:0]    waddr;
    logic [IW-1:0]    wr_inc, wr_dec, rd_inc;
    logic [IW-1:0]    rd_addr, peek_addr;
    logic [WIDTH-1:0] rd_data, peek_raw;
    logic             is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    assign wr_inc = IW'(ptr_inc(32'(wr_ptr_q), DEPTH));
    assign wr_dec = IW'(ptr_dec(32'(wr_ptr_q), DEPTH));
    assign rd_inc = IW'(ptr_inc(32'(rd_ptr_q), DEPTH));

    // LIFO top sits just below wr_ptr; peeking walks further down from there.
    assign rd_addr   = (mode_q == MODE_FIFO) ? rd_ptr_q : wr_dec;
    assign peek_addr = (mode_q == MODE_FIFO)
                     ? IW'(ptr_add(32'(rd_ptr_q), 32'(peek_idx), DEPTH))
                     : IW'(ptr_add(32'(wr_dec), DEPTH - (32'(peek_idx) % DEPTH), DEPTH));

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        waddr       = wr_ptr_q;
        // Mode may only change while empty (pre-edge count) or on clear.
        mode_d      = (clear || is_empty) ? mode_sel : mode_q;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push && (!pop || is_empty)) begin
            // push+pop on empty degenerates to a plain push
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                we       = 1'b1;
                wr_ptr_d = wr_inc;
                count_d  = count_q + CW'(1);
            end
        end else if (pop && !push) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CW'(1);
                if (mode_q == MODE_FIFO) begin
                    rd_ptr_d = rd_inc;
                end else begin
                    wr_ptr_d = wr_dec;
                end
            end
        end else if (push && pop) begin
            we = 1'b1;
            if (mode_q == MODE_FIFO) begin
                // Write lands in the slot being vacated, so legal when full.
                wr_ptr_d = wr_inc;
                rd_ptr_d = rd_inc;
            end else begin
                waddr = wr_dec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mode_q      <= MODE_LIFO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sq_regfile #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_regfile (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (din),
        .raddr_a_i(rd_addr),
        .rdata_a_o(rd_data),
        .raddr_b_i(peek_addr),
        .rdata_b_o(peek_raw)
    );

    assign peek_valid = (32'(peek_idx) < 32'(count_q));
    assign dout       = is_empty ? '0 : rd_data;
    assign peek_data  = peek_valid ? peek_raw : '0;
    assign count      = count_q;
    assign empty      = is_empty;
    assign full       = is_full;
    assign mode       = mode_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_stack_queue.sv
// Self-checking bench for stack_queue (WIDTH=8, DEPTH=4): directed scenarios
// followed by randomized traffic compared against a queue-based model.
module tb_stack_queue;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst, clear, mode_sel, push, pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout, peek_data;
    logic [IW-1:0]    peek_idx;
    logic             peek_valid, empty, full, mode, overflow, underflow;
    logic [CW-1:0]    count;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: front of queue = oldest entry, back = newest.
    logic [WIDTH-1:0] m_q[$];
    logic             m_mode, m_ovf, m_unf;

    always #5 clk = ~clk;

    stack_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .mode_sel  (mode_sel),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .peek_idx  (peek_idx),
        .peek_data (peek_data),
        .peek_valid(peek_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .mode      (mode),
        .overflow  (overflow),
        .underflow (underflow)
    );

    function automatic void model_reset();
        m_q.delete();
        m_mode = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endfunction

    function automatic void model_edge(input logic c, input logic p, input logic po,
                                       input logic [WIDTH-1:0] d, input logic ms);
        logic new_mode;
        if (c) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_mode = ms;
            return;
        end
        new_mode = (m_q.size() == 0) ? ms : m_mode;
        if (p && (!po || m_q.size() == 0)) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(d);
        end else if (po && !p) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else if (m_mode) void'(m_q.pop_front());
            else void'(m_q.pop_back());
        end else if (p && po) begin
            if (m_mode) begin
                void'(m_q.pop_front());
                m_q.push_back(d);
            end else begin
                m_q[m_q.size() - 1] = d;
            end
        end
        m_mode = new_mode;
    endfunction

    function automatic logic [WIDTH-1:0] exp_peek(input int idx);
        if (idx >= m_q.size()) return '0;
        return m_mode ? m_q[idx] : m_q[m_q.size() - 1 - idx];
    endfunction

    // One clock: drive at negedge, update model at posedge, return at next negedge.
    task automatic cyc(input logic p, input logic po, input logic c, input logic [WIDTH-1:0] d);
        push  = p;
        pop   = po;
        clear = c;
        din   = d;
        @(posedge clk);
        model_edge(c, p, po, d, mode_sel);
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (mode !== 1'b0) begin n_fail++; $display("FAIL reset_mode: got %b want 0", mode); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_lifo_fill();
        logic [WIDTH-1:0] exp_pop[3] = '{8'h33, 8'h22, 8'h11};
        mode_sel = 1'b0;
        cyc(1, 0, 0, 8'h11); cyc(1, 0, 0, 8'h22); cyc(1, 0, 0, 8'h33); cyc(1, 0, 0, 8'h44);
        n_checks++; if (full !== 1'b1 || count !== 4) begin
            n_fail++; $display("FAIL lifo_full: got full=%b count=%0d want 1/4", full, count); end
        n_checks++; if (dout !== 8'h44) begin n_fail++; $display("FAIL lifo_top: got %h want 44", dout); end
        cyc(1, 0, 0, 8'h55);
        n_checks++; if (overflow !== 1'b1 || count !== 4 || dout !== 8'h44) begin
            n_fail++; $display("FAIL lifo_overflow: got ovf=%b count=%0d dout=%h want 1/4/44",
                               overflow, count, dout); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 8'h00);
            n_checks++; if (dout !== exp_pop[i]) begin
                n_fail++; $display("FAIL lifo_pop%0d: got %h want %h", i, dout, exp_pop[i]); end
        end
        cyc(0, 1, 0, 8'h00);
        n_checks++; if (empty !== 1'b1 || dout !== 8'h00) begin
            n_fail++; $display("FAIL lifo_drain: got empty=%b dout=%h want 1/00", empty, dout); end
    endtask

    task automatic test_underflow_clear();
        cyc(0, 1, 0, 8'h00);
        n_checks++; if (underflow !== 1'b1 || count !== 0) begin
            n_fail++; $display("FAIL underflow_set: got unf=%b count=%0d want 1/0", underflow, count); end
        cyc(0, 0, 1, 8'h00);
        n_checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL clear_flags: got unf=%b ovf=%b want 0/0", underflow, overflow); end
        cyc(1, 1, 0, 8'h7A);
        n_checks++; if (count !== 1 || dout !== 8'h7A || underflow !== 1'b0) begin
            n_fail++; $display("FAIL pushpop_empty: got count=%0d dout=%h unf=%b want 1/7a/0",
                               count, dout, underflow); end
    endtask

    task automatic test_peek_replace();
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'h01); cyc(1, 0, 0, 8'h02);
        cyc(1, 1, 0, 8'h09);
        n_checks++; if (count !== 2 || dout !== 8'h09) begin
            n_fail++; $display("FAIL lifo_replace: got count=%0d dout=%h want 2/09", count, dout); end
        peek_idx = 2'd1; #1;
        n_checks++; if (peek_valid !== 1'b1 || peek_data !== 8'h01) begin
            n_fail++; $display("FAIL peek1: got v=%b d=%h want 1/01", peek_valid, peek_data); end
        peek_idx = 2'd2; #1;
        n_checks++; if (peek_valid !== 1'b0 || peek_data !== 8'h00) begin
            n_fail++; $display("FAIL peek2: got v=%b d=%h want 0/00", peek_valid, peek_data); end
        peek_idx = 2'd0;
    endtask

    task automatic test_mode_switch();
        mode_sel = 1'b1;
        cyc(0, 0, 0, 8'h00);
        n_checks++; if (mode !== 1'b0) begin n_fail++; $display("FAIL mode_hold: got %b want 0", mode); end
        cyc(0, 1, 0, 8'h00); cyc(0, 1, 0, 8'h00);
        n_checks++; if (mode !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL mode_drain: got mode=%b empty=%b want 0/1", mode, empty); end
        cyc(0, 0, 0, 8'h00);
        n_checks++; if (mode !== 1'b1) begin n_fail++; $display("FAIL mode_load: got %b want 1", mode); end
        cyc(1, 0, 0, 8'hA1); cyc(1, 0, 0, 8'hB2); cyc(1, 0, 0, 8'hC3);
        peek_idx = 2'd2; #1;
        n_checks++; if (dout !== 8'hA1 || peek_data !== 8'hC3) begin
            n_fail++; $display("FAIL fifo_order: got dout=%h peek=%h want a1/c3", dout, peek_data); end
        peek_idx = 2'd0;
    endtask

    task automatic test_fifo_wrap();
        logic [WIDTH-1:0] tail[4] = '{8'h14, 8'h15, 8'h16, 8'hEE};
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, WIDTH'(8'h10 + i));
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dout !== WIDTH'(8'h10 + i)) begin
                n_fail++; $display("FAIL wrap_head%0d: got %h want %h", i, dout, 8'h10 + i); end
            cyc(0, 1, 0, 8'h00);
        end
        for (int i = 4; i < 7; i++) cyc(1, 0, 0, WIDTH'(8'h10 + i));
        n_checks++; if (count !== 4 || full !== 1'b1 || dout !== 8'h13) begin
            n_fail++; $display("FAIL wrap_full: got count=%0d full=%b dout=%h want 4/1/13",
                               count, full, dout); end
        cyc(1, 1, 0, 8'hEE);
        n_checks++; if (count !== 4 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_pushpop: got count=%0d ovf=%b want 4/0", count, overflow); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dout !== tail[i]) begin
                n_fail++; $display("FAIL wrap_tail%0d: got %h want %h", i, dout, tail[i]); end
            cyc(0, 1, 0, 8'h00);
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_random();
        logic p, po, c;
        for (int i = 0; i < 600; i++) begin
            c        = ($urandom_range(0, 49) == 0);
            p        = ($urandom_range(0, 99) < ((i % 200) < 100 ? 65 : 35));
            po       = ($urandom_range(0, 99) < ((i % 200) < 100 ? 35 : 65));
            mode_sel = $urandom_range(0, 1) == 1;
            peek_idx = IW'($urandom_range(0, DEPTH - 1));
            cyc(p, po, c, WIDTH'($urandom));
            n_checks++; if (count !== CW'(m_q.size())) begin
                n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, m_q.size()); end
            n_checks++; if (dout !== exp_peek(0)) begin
                n_fail++; $display("FAIL rnd_dout@%0d: got %h want %h", i, dout, exp_peek(0)); end
            n_checks++; if (peek_data !== exp_peek(int'(peek_idx))) begin
                n_fail++; $display("FAIL rnd_peek@%0d: got %h want %h", i, peek_data,
                                   exp_peek(int'(peek_idx))); end
            n_checks++; if (peek_valid !== (int'(peek_idx) < m_q.size())) begin
                n_fail++; $display("FAIL rnd_peek_valid@%0d: got %b", i, peek_valid); end
            n_checks++; if ({empty, full} !== {m_q.size() == 0, m_q.size() == DEPTH}) begin
                n_fail++; $display("FAIL rnd_empty_full@%0d: got %b%b size %0d", i, empty, full,
                                   m_q.size()); end
            n_checks++; if ({mode, overflow, underflow} !== {m_mode, m_ovf, m_unf}) begin
                n_fail++; $display("FAIL rnd_mode_flags@%0d: got %b%b%b want %b%b%b", i, mode,
                                   overflow, underflow, m_mode, m_ovf, m_unf); end
        end
    endtask

    task automatic test_async_reset();
        mode_sel = 1'b1;
        cyc(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, WIDTH'(8'h60 + i));
        cyc(0, 1, 0, 8'h00);
        n_checks++; if (count !== 3 || overflow !== 1'b1 || mode !== 1'b1) begin
            n_fail++; $display("FAIL arst_setup: got count=%0d ovf=%b mode=%b want 3/1/1",
                               count, overflow, mode); end
        mode_sel = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (count !== 0 || empty !== 1'b1 || mode !== 1'b0) begin
            n_fail++; $display("FAIL arst_state: got count=%0d empty=%b mode=%b want 0/1/0",
                               count, empty, mode); end
        n_checks++; if ({overflow, underflow} !== 2'b00 || dout !== 8'h00) begin
            n_fail++; $display("FAIL arst_out: got flags=%b dout=%h want 00/00",
                               {overflow, underflow}, dout); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; mode_sel = 1'b0; push = 1'b0; pop = 1'b0;
        din = '0; peek_idx = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_lifo_fill();
        test_underflow_clear();
        test_peek_replace();
        test_mode_switch();
        test_fifo_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_queue.md
Name: stack_queue

Overview:
Parametrised LIFO/FIFO buffer and successor to the fixed 4x16 stack. Storage is a circular register array. The mode is selectable at run time, but only while the buffer is empty. Adds a correctly sized occupancy count, peek at arbitrary depth, a synchronous clear, and sticky overflow/underflow error flags. Sits between a command producer and a consumer wherever ordered buffering is needed.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2; need not be a power of two)
CW, $clog2(DEPTH+1), count width (derived localparam; not overridable)
IW, $clog2(DEPTH), pointer and peek index width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
clear  in  1  synchronous flush; highest priority after rst
mode_sel  in  1  requested mode: 0 = LIFO, 1 = FIFO
push  in  1  write din this cycle
pop  in  1  remove the current output element this cycle
din  in  WIDTH  push data
dout  out  WIDTH  current element: top (LIFO) or head (FIFO); 0 when empty
peek_idx  in  IW  depth from top/head to inspect
peek_data  out  WIDTH  element at peek_idx; 0 when not peek_valid
peek_valid  out  1  peek_idx < count
count  out  CW  occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
mode  out  1  active mode register
overflow  out  1  sticky: a push was dropped
underflow  out  1  sticky: a pop hit empty

Behaviour:
- Reset (async): count=0, wr_ptr=0, rd_ptr=0, mode=0 (LIFO), overflow=0, underflow=0. Memory is not reset. dout and peek_data read 0 because they are masked by empty/peek_valid.
- Pointers wrap explicitly: DEPTH-1 -> 0 on increment, 0 -> DEPTH-1 on decrement.
- Invariant: rd_ptr == (wr_ptr - count) mod DEPTH in both modes.
- dout and peek_data are combinational from state with zero latency. Written data appears on dout the cycle after the push edge.
  - LIFO: dout = mem[wr_ptr-1]; peek_data = mem[wr_ptr-1-peek_idx].
  - FIFO: dout = mem[rd_ptr]; peek_data = mem[rd_ptr+peek_idx].
  - All indices mod DEPTH.
- mode loads mode_sel on any edge where count==0 and clear=0 (the pre-edge count). Otherwise mode holds. The request is silently ignored until the buffer drains. Operations on that same edge use the old mode, which is equivalent because the buffer is empty.
- Per-edge actions, evaluated in priority order:
  1. clear=1: count=0, rd_ptr=wr_ptr=0, overflow=underflow=0. push/pop are ignored; mode loads mode_sel.
  2. push & !pop & !full: mem[wr_ptr]<=din, wr_ptr++, count++.
  3. push & !pop & full: no state change except overflow<=1.
  4. pop & !push & !empty:
     - LIFO: wr_ptr--, rd_ptr unchanged.
     - FIFO: rd_ptr++.
     - Both modes: count--.
  5. pop & !push & empty: underflow<=1, nothing else changes.
  6. push & pop & !empty, count unchanged:
     - LIFO: mem[wr_ptr-1]<=din (replace top).
     - FIFO: mem[wr_ptr]<=din, wr_ptr++, rd_ptr++. Legal even when full, because the write lands in the slot being vacated.
  7. push & pop & empty: treated as push only (count=1); underflow is not set.
  8. No push and no pop: hold.
- overflow and underflow clear only on rst or clear.
- Synthesisable, single clock domain. No X propagation on any output after reset.

Decomposition:
- Package stack_queue_pkg:
  - constants MODE_LIFO=1'b0 and MODE_FIFO=1'b1;
  - functions ptr_inc(ptr, depth), ptr_dec(ptr, depth) and ptr_add(ptr, off, depth), all with explicit wrap.
- Sub-module sq_regfile: DEPTH x WIDTH array with one synchronous write port and two asynchronous read ports (dout, peek), no reset.
- Pointer, count, mode and flag control stay in stack_queue.

Test Plan:
(All with WIDTH=8, DEPTH=4.)
1. Reset, LIFO: push 0x11,0x22,0x33,0x44 -> full=1, count=4, dout=0x44. Push 0x55 -> overflow=1, count=4, dout=0x44. Pop x4 -> dout 0x33,0x22,0x11, then empty=1 with dout=0.
2. Empty LIFO: pop -> underflow=1, count=0. Then clear -> underflow=0. Then push+pop with 0x7A on empty -> count=1, dout=0x7A, underflow=0.
3. LIFO holding 0x01,0x02: push+pop 0x09 -> count=2, dout=0x09; peek_idx=1 -> 0x01, peek_valid=1; peek_idx=2 -> peek_valid=0, peek_data=0.
4. Mode switch:
   - with count=2, set mode_sel=1 -> mode stays 0;
   - pop x2 -> mode=1 on the edge after empty;
   - push 0xA1,0xB2,0xC3 -> dout=0xA1, peek_idx=2 -> 0xC3.
5. FIFO wrap: push 4, pop 3, push 3 -> pointers wrap, count=4, entries pop out in push order. Full with push+pop of 0xEE -> count=4, no overflow; 0xEE emerges last.
6. rst asserted mid-stream (count=3, overflow=1, mode=FIFO) between clock edges -> immediately count=0, empty=1, mode=0, flags=0, dout=0.
